// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl: sequencer for the SHA-256 compression round datapath and
// message-schedule unit. Takes one padded block per handshake, loads the
// working variables, steps ROUNDS single-cycle rounds, folds the result into
// the chaining state and offers the digest on a valid/ready handshake.
// Optional feature macro: SHA_ABORT_EN adds an 'abort' input that drops an
// in-flight block without touching the chaining state.
module sha256_round_ctrl #(
  parameter int ROUNDS = 64,
  parameter int IDX_W  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SHA_ABORT_EN
  input  logic             abort,
`endif
  input  logic             blk_valid,
  input  logic             blk_first,
  output logic             blk_ready,
  output logic             ws_load,
  output logic             wv_init,
  output logic             rnd_en,
  output logic [IDX_W-1:0] rnd_idx,
  input  logic [255:0]     wv_in,
  output logic [255:0]     h_state,
  output logic             dig_valid,
  input  logic             dig_ready,
  output logic             busy
);

  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ROUND = 3'd2;
  localparam logic [2:0] S_FINAL = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  logic [2:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [255:0]     r_h;

  logic             w_lastRound;
  logic             w_abort;
  logic [255:0]     w_hSum;

  assign w_lastRound = (r_idx == LAST_IDX);

`ifdef SHA_ABORT_EN
  // Abort only matters while a block is in flight; the digest in DONE is kept.
  assign w_abort = abort && ((r_state == S_LOAD) || (r_state == S_ROUND) ||
                             (r_state == S_FINAL));
`else
  assign w_abort = 1'b0;
`endif

  // Feed-forward add: eight independent 32-bit sums, no carry between words.
  always_comb begin
    w_hSum = '0;
    for (int i = 0; i < 8; i++) begin
      w_hSum[32*i +: 32] = r_h[32*i +: 32] + wv_in[32*i +: 32];
    end
  end

  // Block sequencing, round counter and chaining-state update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_h     <= IV;
    end else if (w_abort) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (blk_valid) begin
            r_state <= S_LOAD;
            r_idx   <= '0;
            if (blk_first) begin
              r_h <= IV;
            end
          end
        end
        S_LOAD: begin
          r_state <= S_ROUND;
          r_idx   <= '0;
        end
        S_ROUND: begin
          if (w_lastRound) begin
            r_state <= S_FINAL;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_FINAL: begin
          r_h     <= w_hSum;
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (dig_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_idx   <= '0;
        end
      endcase
    end
  end

  assign blk_ready = (r_state == S_IDLE);
  assign ws_load   = (r_state == S_LOAD);
  assign wv_init   = (r_state == S_LOAD);
  assign rnd_en    = (r_state == S_ROUND);
  assign rnd_idx   = r_idx;
  assign h_state   = r_h;
  assign dig_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);

endmodule

// File: doc/sha256_round_ctrl.md
Name: sha256_round_ctrl

Overview:
Sequencer for the SHA-256 compression round datapath and message-schedule unit. Accepts one 512-bit block request per handshake and loads the datapath working variables from the chaining state. Drives 64 single-cycle rounds with a round index for the K ROM and W schedule, then performs the feed-forward add into the chaining state and presents the 256-bit digest on a valid/ready handshake. Sits between the block-fetch/padding logic and the round datapath in the miner core.

Parameters:
ROUNDS, 64, number of compression rounds per block; must be ≤ 2**IDX_W
IDX_W, 6, width of round index

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
blk_valid  in  1  padded block available (schedule unit holds the 512-bit block)
blk_first  in  1  qualified by blk_valid; 1 = first block of message, restart from IV
blk_ready  out  1  controller can accept a block
ws_load  out  1  one-cycle pulse: schedule unit latches block, W0..W15
wv_init  out  1  one-cycle pulse: datapath loads a..h from h_state
rnd_en  out  1  datapath performs one round this cycle
rnd_idx  out  IDX_W  round index for Ki/Wi select
wv_in  in  256  datapath working vars {a,b,c,d,e,f,g,h}, a in [255:224]
h_state  out  256  chaining state H0..H7, H0 in [255:224]
dig_valid  out  1  digest valid
dig_ready  in  1  consumer accepts digest
busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, LOAD, ROUND, FINAL, DONE.
- Reset (rst_n=0 at posedge): state=IDLE, h_state=IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19), rnd_idx=0. All strobes are 0. Reset mid-block abandons the block; h_state returns to IV.
- IDLE: blk_ready=1. On blk_valid&blk_ready → LOAD. If blk_first=1, h_state<=IV in the same edge; otherwise h_state is retained (chaining).
- LOAD (1 cycle): ws_load=1, wv_init=1, rnd_idx=0 → ROUND.
- ROUND (ROUNDS cycles): rnd_en=1, rnd_idx = 0,1,…,ROUNDS-1, one per cycle. The datapath applies round rnd_idx on the edge closing that cycle. Leaving ROUND after rnd_idx=ROUNDS-1 → FINAL; rnd_idx returns to 0.
- FINAL (1 cycle): rnd_en=0. Each 32-bit word Hi<=Hi+wv_in word i, modulo 2^32; carries never cross words → DONE.
- DONE: dig_valid=1, digest = h_state. Hold until dig_valid&dig_ready, then → IDLE. blk_ready=0 while in DONE; no new block is taken in the same cycle as the digest handshake.
- Latency: accept at edge T; LOAD in cycle T+1; rounds T+2..T+65; FINAL T+66; dig_valid first high in cycle T+67 (67 cycles accept-to-valid).
- blk_valid outside IDLE is ignored. blk_first is sampled only at the accept edge.
- rnd_en, ws_load and wv_init are mutually exclusive and are 0 outside their states.
- h_state is stable outside accept-with-first and FINAL.

Optional Feature:
SHA_ABORT_EN: adds input abort (1 bit). When abort=1 in LOAD, ROUND or FINAL, next state=IDLE and rnd_en drops the following cycle. h_state is not updated by the aborted block, and no dig_valid is issued for it. In DONE, abort is ignored. Without the macro there is no port, and a block always runs to DONE.

Test Plan:
- Reset, then single block "abc" (blk_first=1) with reference datapath model → dig_valid at accept+67, digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Monitor during a block → ws_load and wv_init each pulse once in cycle T+1; rnd_en high exactly 64 consecutive cycles; rnd_idx 0..63 with no gaps or repeats.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (second block blk_first=0) → second digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- dig_ready held 0 for 10 cycles in DONE, blk_valid=1 throughout → dig_valid and digest stable, blk_ready=0, no new accept until one cycle after the handshake.
- rst_n=0 at round 30 → next cycle state IDLE, h_state=IV, rnd_en=0. A following "abc" block gives the correct digest.
- (SHA_ABORT_EN) abort at round 40 of a chained block → IDLE, h_state unchanged. A re-issued block with blk_first=0 yields the same digest as an uninterrupted run.
